// File: rtl/dcpu_core.sv
// dcpu_core: parametrised multi-cycle accumulator CPU with a single shared
// ready-handshake memory port, stack ops, CALL/RET, HALT and illegal-opcode trap.
module dcpu_core #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter logic [AW-1:0] SP_INIT = {{(AW-1){1'b1}}, 1'b0}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          halted,
  output logic          illegal
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_OPER   = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_RD     = 3'd4;
  localparam logic [2:0] S_WR     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'hc1;
  localparam logic [7:0] OP_STA  = 8'hc2;
  localparam logic [7:0] OP_ADD  = 8'hc3;
  localparam logic [7:0] OP_JMP  = 8'hc4;
  localparam logic [7:0] OP_JZ   = 8'hc5;
  localparam logic [7:0] OP_JC   = 8'hc6;
  localparam logic [7:0] OP_SUB  = 8'hc7;
  localparam logic [7:0] OP_CMP  = 8'hc8;
  localparam logic [7:0] OP_JNC  = 8'hc9;
  localparam logic [7:0] OP_PUSH = 8'hca;
  localparam logic [7:0] OP_POP  = 8'hcb;
  localparam logic [7:0] OP_CALL = 8'hcc;
  localparam logic [7:0] OP_RET  = 8'hcd;
  localparam logic [7:0] OP_LDA  = 8'hce;
  localparam logic [7:0] OP_HALT = 8'hcf;

  localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

  logic [2:0]    r_state;
  logic [7:0]    r_ir;
  logic [DW-1:0] r_opr;
  logic [DW-1:0] r_acc;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_sp;
  logic          r_z;
  logic          r_c;
  logic          r_illegal;
  logic [AW-1:0] r_ea;   // data-access address, latched before RD/WR
  logic [DW-1:0] r_wd;   // write data, latched before WR

  // Extra top bit holds carry (ADD) or borrow (SUB/CMP: set iff acc < imm).
  logic [DW:0] w_sum;
  logic [DW:0] w_diff;
  assign w_sum  = {1'b0, r_acc} + {1'b0, r_opr};
  assign w_diff = {1'b0, r_acc} - {1'b0, r_opr};

  // Port outputs decode from registered state; requests are masked during reset
  // because the reset state is FETCH.
  assign mem_rd    = !rst && (r_state == S_FETCH || r_state == S_OPER || r_state == S_RD);
  assign mem_wr    = !rst && (r_state == S_WR);
  assign mem_addr  = (r_state == S_RD || r_state == S_WR) ? r_ea : r_pc;
  assign mem_wdata = (r_state == S_WR) ? r_wd : '0;
  assign halted    = (r_state == S_HALT);
  assign illegal   = r_illegal;

  // Instruction sequencer: fetch / decode / operand / execute / data access.
  // NOTE: all state here uses non-blocking assignments so every register sees
  // pre-edge values of the others, matching real flip-flop behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_ir      <= '0;
      r_opr     <= '0;
      r_acc     <= '0;
      r_pc      <= '0;
      r_sp      <= SP_INIT;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
      r_illegal <= 1'b0;
      r_ea      <= '0;
      r_wd      <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ready) begin
          r_ir    <= mem_rdata[7:0];
          r_pc    <= r_pc + ONE_A;
          r_state <= S_DECODE;
        end
        S_DECODE: case (r_ir)
          OP_NOP:  r_state <= S_FETCH;
          OP_HALT: r_state <= S_HALT;
          OP_PUSH: begin
            r_ea    <= r_sp;
            r_wd    <= r_acc;
            r_state <= S_WR;
          end
          OP_POP, OP_RET: begin
            r_ea    <= r_sp + ONE_A;
            r_state <= S_RD;
          end
          OP_LDI, OP_STA, OP_ADD, OP_JMP, OP_JZ, OP_JC, OP_SUB, OP_CMP,
          OP_JNC, OP_CALL, OP_LDA: r_state <= S_OPER;
          default: begin
            r_illegal <= 1'b1;
            r_state   <= S_HALT;
          end
        endcase
        S_OPER: if (mem_ready) begin
          r_opr   <= mem_rdata;
          r_pc    <= r_pc + ONE_A;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          case (r_ir)
            OP_LDI: r_acc <= r_opr;
            OP_ADD: begin
              r_acc <= w_sum[DW-1:0];
              r_c   <= w_sum[DW];
              r_z   <= (w_sum[DW-1:0] == '0);
            end
            OP_SUB: begin
              r_acc <= w_diff[DW-1:0];
              r_c   <= w_diff[DW];
              r_z   <= (w_diff[DW-1:0] == '0);
            end
            OP_CMP: begin
              r_c <= w_diff[DW];
              r_z <= (w_diff[DW-1:0] == '0);
            end
            OP_JMP: r_pc <= r_opr[AW-1:0];
            OP_JZ:  if (r_z)  r_pc <= r_opr[AW-1:0];
            OP_JC:  if (r_c)  r_pc <= r_opr[AW-1:0];
            OP_JNC: if (!r_c) r_pc <= r_opr[AW-1:0];
            OP_LDA: begin
              r_ea    <= r_opr[AW-1:0];
              r_state <= S_RD;
            end
            OP_STA: begin
              r_ea    <= r_opr[AW-1:0];
              r_wd    <= r_acc;
              r_state <= S_WR;
            end
            OP_CALL: begin
              r_ea    <= r_sp;
              r_wd    <= DW'(r_pc);
              r_state <= S_WR;
            end
            default: ;
          endcase
        end
        S_RD: if (mem_ready) begin
          r_state <= S_FETCH;
          case (r_ir)
            OP_POP: begin
              r_acc <= mem_rdata;
              r_sp  <= r_sp + ONE_A;
            end
            OP_RET: begin
              r_pc <= mem_rdata[AW-1:0];
              r_sp <= r_sp + ONE_A;
            end
            default: r_acc <= mem_rdata;  // LDA
          endcase
        end
        S_WR: if (mem_ready) begin
          r_state <= S_FETCH;
          case (r_ir)
            OP_PUSH: r_sp <= r_sp - ONE_A;
            OP_CALL: begin
              r_sp <= r_sp - ONE_A;
              r_pc <= r_opr[AW-1:0];
            end
            default: ;  // STA
          endcase
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_dcpu_core.sv
// tb_dcpu_core: runs directed and random programs on an 8-bit core (plus a
// 16/10-bit build) and compares against an ISA-level reference interpreter.
module tb_dcpu_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int   ready_mode = 0;  // 0: always ready, 1: random stalls, 2: block reads @80

  always #5 clk = ~clk;

  // 8-bit core
  logic [7:0] rdata8, wd8, addr8;
  logic       rd8, wr8, halted8, illegal8;
  logic [7:0] mem8  [256];
  logic [7:0] init8 [256];

  dcpu_core #(.DW(8), .AW(8)) u8 (
    .clk(clk), .rst(rst), .mem_rdata(rdata8), .mem_ready(rdy),
    .mem_rd(rd8), .mem_wr(wr8), .mem_addr(addr8), .mem_wdata(wd8),
    .halted(halted8), .illegal(illegal8)
  );

  // 16-bit data / 10-bit address core
  logic [15:0] rdata16, wd16;
  logic [9:0]  addr16;
  logic        rd16, wr16, halted16, illegal16;
  logic [15:0] mem16  [1024];
  logic [15:0] init16 [1024];

  dcpu_core #(.DW(16), .AW(10)) u16 (
    .clk(clk), .rst(rst), .mem_rdata(rdata16), .mem_ready(rdy),
    .mem_rd(rd16), .mem_wr(wr16), .mem_addr(addr16), .mem_wdata(wd16),
    .halted(halted16), .illegal(illegal16)
  );

  assign rdata8  = mem8[addr8];
  assign rdata16 = mem16[addr16];

  // Memories reload their image while reset is held, otherwise take writes.
  always @(posedge clk) begin
    if (rst) begin
      mem8  <= init8;
      mem16 <= init16;
    end else begin
      if (wr8 && rdy)  mem8[addr8]   <= wd8;
      if (wr16 && rdy) mem16[addr16] <= wd16;
    end
  end

  // Ready generator, changes away from the rising edge.
  always @(negedge clk) begin
    case (ready_mode)
      1:       rdy <= 1'($urandom_range(0, 1));
      2:       rdy <= !(rd8 && addr8 == 8'd80);
      default: rdy <= 1'b1;
    endcase
  end

  // Protocol monitor on the 8-bit port.
  int         viol = 0;
  logic       p_hold = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
  logic [7:0] p_addr = '0, p_wd = '0;
  always @(posedge clk) begin
    if (rst) begin
      p_hold <= 1'b0;
    end else begin
      if (rd8 && wr8) viol <= viol + 1;
      else if (p_hold && (rd8 != p_rd || wr8 != p_wr || addr8 != p_addr || wd8 != p_wd))
        viol <= viol + 1;
      p_hold <= (rd8 || wr8) && !rdy;
      p_rd   <= rd8;
      p_wr   <= wr8;
      p_addr <= addr8;
      p_wd   <= wd8;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ISA-level reference model of the 8-bit core.
  int rm [256];
  int m_acc, m_pc, m_sp, m_z, m_c, m_ill;

  task automatic model_run(output int cyc);
    int op, opr, t, halt;
    foreach (rm[i]) rm[i] = int'(init8[i]);
    m_acc = 0; m_pc = 0; m_sp = 254; m_z = 0; m_c = 0; m_ill = 0; halt = 0; cyc = 0;
    for (int step = 0; step < 1000 && halt == 0; step++) begin
      op = rm[m_pc]; m_pc = (m_pc + 1) % 256;
      case (op)
        8'h00: cyc += 2;
        8'hcf: begin halt = 1; cyc += 2; end
        8'hca: begin rm[m_sp] = m_acc; m_sp = (m_sp + 255) % 256; cyc += 3; end
        8'hcb: begin m_sp = (m_sp + 1) % 256; m_acc = rm[m_sp]; cyc += 3; end
        8'hcd: begin m_sp = (m_sp + 1) % 256; m_pc = rm[m_sp]; cyc += 3; end
        8'hc1, 8'hc2, 8'hc3, 8'hc4, 8'hc5, 8'hc6, 8'hc7, 8'hc8, 8'hc9, 8'hcc, 8'hce: begin
          opr = rm[m_pc]; m_pc = (m_pc + 1) % 256;
          cyc += 4;
          case (op)
            8'hc1: m_acc = opr;
            8'hc3: begin t = m_acc + opr; m_c = int'(t > 255); m_acc = t % 256; m_z = int'(m_acc == 0); end
            8'hc7: begin m_c = int'(m_acc < opr); m_acc = (m_acc - opr + 256) % 256; m_z = int'(m_acc == 0); end
            8'hc8: begin m_c = int'(m_acc < opr); m_z = int'(m_acc == opr); end
            8'hc4: m_pc = opr;
            8'hc5: if (m_z != 0) m_pc = opr;
            8'hc6: if (m_c != 0) m_pc = opr;
            8'hc9: if (m_c == 0) m_pc = opr;
            8'hce: begin m_acc = rm[opr]; cyc += 1; end
            8'hc2: begin rm[opr] = m_acc; cyc += 1; end
            default: begin  // CALL
              rm[m_sp] = m_pc; m_sp = (m_sp + 255) % 256; m_pc = opr; cyc += 1;
            end
          endcase
        end
        default: begin halt = 1; m_ill = 1; cyc += 2; end
      endcase
    end
  endtask

  task automatic clear_init();
    foreach (init8[i])  init8[i]  = 8'h00;
    foreach (init16[i]) init16[i] = 16'h0000;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs init8 on the 8-bit core and checks it against the model.
  task automatic run_prog(input string tag, input bit stall, output int cyc);
    int v0, mcyc, mism, reqs;
    ready_mode = stall ? 1 : 0;
    v0 = viol;
    apply_reset();
    cyc = 0;
    while (!halted8 && cyc < 3000) begin
      @(posedge clk); cyc++; #1;
    end
    check({tag, "_halted"}, 32'(halted8), 32'd1);
    reqs = 0;
    repeat (4) begin
      @(negedge clk);
      if (rd8 || wr8) reqs++;
    end
    check({tag, "_idle"}, reqs, 0);
    model_run(mcyc);
    check({tag, "_acc"}, 32'(u8.r_acc), m_acc);
    check({tag, "_z"}, 32'(u8.r_z), m_z);
    check({tag, "_c"}, 32'(u8.r_c), m_c);
    check({tag, "_sp"}, 32'(u8.r_sp), m_sp);
    check({tag, "_pc"}, 32'(u8.r_pc), m_pc);
    check({tag, "_illegal"}, 32'(illegal8), m_ill);
    mism = 0;
    foreach (mem8[i]) if (int'(mem8[i]) != rm[i]) mism++;
    check({tag, "_mem"}, mism, 0);
    if (!stall) check({tag, "_cycles"}, cyc, mcyc);
    check({tag, "_proto"}, viol - v0, 0);
  endtask

  task automatic load_bytes(input int base, input logic [7:0] b [$]);
    foreach (b[i]) init8[base + i] = b[i];
  endtask

  task automatic gen_random();
    int pos, k;
    logic [7:0] jop [4];
    jop[0] = 8'hc4; jop[1] = 8'hc5; jop[2] = 8'hc6; jop[3] = 8'hc9;
    clear_init();
    for (int a = 100; a < 200; a++) init8[a] = 8'($urandom_range(0, 255));
    pos = 0;
    for (int n = 0; n < 12; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3: begin
          init8[pos] = (k == 0) ? 8'hc1 : (k == 1) ? 8'hc3 : (k == 2) ? 8'hc7 : 8'hc8;
          init8[pos + 1] = 8'($urandom_range(0, 255));
          pos += 2;
        end
        4, 5: begin
          init8[pos] = (k == 4) ? 8'hc2 : 8'hce;
          init8[pos + 1] = 8'($urandom_range(100, 199));
          pos += 2;
        end
        6: begin init8[pos] = 8'hca; pos += 1; end
        7: begin init8[pos] = 8'hcb; pos += 1; end
        8: begin  // jump over a following LDI
          init8[pos]     = jop[$urandom_range(0, 3)];
          init8[pos + 1] = 8'(pos + 4);
          init8[pos + 2] = 8'hc1;
          init8[pos + 3] = 8'($urandom_range(0, 255));
          pos += 4;
        end
        default: pos += 1;  // NOP
      endcase
    end
    init8[pos] = 8'hcf;
  endtask

  initial begin
    int cyc, waited;

    // Reset state
    ready_mode = 0;
    clear_init();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rd", 32'(rd8), 32'd0);
    check("rst_wr", 32'(wr8), 32'd0);
    check("rst_addr", 32'(addr8), 32'd0);
    check("rst_wdata", 32'(wd8), 32'd0);
    check("rst_halted", 32'(halted8), 32'd0);
    check("rst_acc", 32'(u8.r_acc), 32'd0);
    check("rst_sp", 32'(u8.r_sp), 32'd254);
    check("rst_sp16", 32'(u16.r_sp), 32'd1022);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("first_fetch_rd", 32'(rd8), 32'd1);
    check("first_fetch_addr", 32'(addr8), 32'd0);

    // Directed programs, each with and without stalls
    for (int s = 0; s < 2; s++) begin
      clear_init();
      load_bytes(0, '{8'hc1, 8'd10, 8'hc3, 8'd5, 8'hc2, 8'd80, 8'hcf});
      run_prog("tp1", s[0], cyc);
      check("tp1_mem80", 32'(mem8[80]), 32'd15);
      check("tp1_acc", 32'(u8.r_acc), 32'd15);
      if (s == 0) check("tp1_cyc", cyc, 15);

      clear_init();
      load_bytes(0, '{8'hc1, 8'd208, 8'hc7, 8'd16, 8'hc8, 8'd65, 8'hc9, 8'd10, 8'hcf});
      load_bytes(10, '{8'hc3, 8'd100, 8'hcf});
      run_prog("tp2", s[0], cyc);
      check("tp2_acc", 32'(u8.r_acc), 32'd36);
      check("tp2_c", 32'(u8.r_c), 32'd1);

      clear_init();
      load_bytes(0, '{8'hc1, 8'd7, 8'hca, 8'hc1, 8'd0, 8'hcb, 8'hcf});
      run_prog("tp3a", s[0], cyc);
      check("tp3a_acc", 32'(u8.r_acc), 32'd7);
      check("tp3a_mem254", 32'(mem8[254]), 32'd7);
      check("tp3a_sp", 32'(u8.r_sp), 32'd254);

      clear_init();
      load_bytes(0, '{8'hcc, 8'd40, 8'hcf});
      init8[40] = 8'hcd;
      run_prog("tp3b", s[0], cyc);
      check("tp3b_mem254", 32'(mem8[254]), 32'd2);
      check("tp3b_pc", 32'(u8.r_pc), 32'd3);
      check("tp3b_sp", 32'(u8.r_sp), 32'd254);
    end

    // Illegal opcode
    clear_init();
    init8[0] = 8'h42;
    run_prog("ill", 1'b0, cyc);
    check("ill_flag", 32'(illegal8), 32'd1);
    check("ill_cyc", cyc, 2);

    // Random straight-line programs
    for (int r = 0; r < 24; r++) begin
      gen_random();
      run_prog($sformatf("rnd%0d", r), r[0], cyc);
    end

    // 16-bit / 10-bit build; HALT opcode carries junk in its upper byte
    clear_init();
    init16[0] = 16'h00c1; init16[1] = 16'hffff;
    init16[2] = 16'h00c3; init16[3] = 16'h0001;
    init16[4] = 16'habcf;
    ready_mode = 0;
    apply_reset();
    cyc = 0;
    while (!halted16 && cyc < 200) begin
      @(posedge clk); cyc++; #1;
    end
    check("w16_halted", 32'(halted16), 32'd1);
    check("w16_cyc", cyc, 10);
    check("w16_acc", 32'(u16.r_acc), 32'd0);
    check("w16_z", 32'(u16.r_z), 32'd1);
    check("w16_c", 32'(u16.r_c), 32'd1);
    check("w16_illegal", 32'(illegal16), 32'd0);

    // Reset pulse while LDA is stalled
    clear_init();
    load_bytes(0, '{8'hc1, 8'h33, 8'hce, 8'd80, 8'hcf});
    ready_mode = 2;
    apply_reset();
    waited = 0;
    while (!(rd8 && addr8 == 8'd80) && waited < 50) begin
      @(negedge clk); waited++;
    end
    check("lda_wait_seen", 32'(rd8 && addr8 == 8'd80), 32'd1);
    repeat (3) @(negedge clk);
    check("lda_held_rd", 32'(rd8), 32'd1);
    check("lda_held_addr", 32'(addr8), 32'd80);
    check("lda_acc_pre", 32'(u8.r_acc), 32'h33);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_acc", 32'(u8.r_acc), 32'd0);
    check("mid_rst_pc", 32'(u8.r_pc), 32'd0);
    check("mid_rst_sp", 32'(u8.r_sp), 32'd254);
    check("mid_rst_ir", 32'(u8.r_ir), 32'd0);
    check("mid_rst_rd", 32'(rd8), 32'd0);
    ready_mode = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_rd", 32'(rd8), 32'd1);
    check("post_rst_addr", 32'(addr8), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
